// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Used by instr_fetch_unit and ifu_fifo.
package ifu_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] word;
    } fifo_entry_t;

    localparam int ENTRY_W = $bits(fifo_entry_t);

    typedef enum logic {
        FETCH_RUN,
        FETCH_HALTED
    } fetch_state_e;

    function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
        return pc + XLEN'(INSTR_BYTES);
    endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Prefetch FIFO holding {pc, word} entries.
// The head is read straight from the storage flops, so data written in one cycle is visible the next.
module ifu_fifo
    import ifu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [ENTRY_W-1:0]       push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic                     head_valid,
    output logic [ENTRY_W-1:0]       head_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]     count_q, count_d;
    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ENTRY_W-1:0] mem_d [DEPTH];
    logic               full;
    logic               do_push;
    logic               do_pop;

    assign full       = (count_q == FULL_COUNT);
    assign head_valid = (count_q != '0);
    assign head_data  = head_valid ? mem_q[rd_ptr_q] : '0;
    assign count      = count_q;

    assign do_pop  = pop & head_valid;
    assign do_push = push & (!full | do_pop);

    // Flush wins over any push or pop in the same cycle.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + (PTR_W + 1)'(do_push) - (PTR_W + 1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch front end: sequential PC generation, credit-limited memory requests and redirect/kill handling.
// Optional misaligned-redirect trap is enabled by defining IFU_MISALIGN_CHECK_EN.
module instr_fetch_unit
    import ifu_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    output logic        fetch_err
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W:0] CREDIT_MAX = (CNT_W + 1)'(DEPTH);

    logic [31:0]        fetch_pc_q, fetch_pc_d;
    logic [31:0]        resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0]   outstanding_q, outstanding_d;
    logic [CNT_W-1:0]   kill_q, kill_d;
    logic [CNT_W-1:0]   fifo_count;
    logic [CNT_W:0]     credits_used;
    logic [31:0]        target_pc;
    logic               halted;
    logic               handshake;
    logic               rvalid_ok;
    logic               drop_resp;
    logic               push;
    logic               pop;
    fifo_entry_t        push_entry;
    fifo_entry_t        head_entry;
    logic [ENTRY_W-1:0] head_data;

    assign target_pc = redirect_pc & 32'hFFFF_FFFC;

    // Credits counted from registered state only, so a pop frees a slot for the next cycle.
    assign credits_used = {1'b0, fifo_count} + {1'b0, outstanding_q};
    assign imem_req     = !reset && !redirect_valid && !halted && (credits_used < CREDIT_MAX);
    assign imem_addr    = fetch_pc_q;
    assign handshake    = imem_req & imem_gnt;

    // A response with nothing owed (e.g. a straggler from before reset) is ignored.
    assign rvalid_ok = imem_rvalid & (outstanding_q != '0);
    assign drop_resp = rvalid_ok & (kill_q != '0);
    assign push      = rvalid_ok & !drop_resp & !redirect_valid;
    assign pop       = instr_valid & instr_ready;

    assign push_entry = '{pc: resp_pc_q, word: imem_rdata};

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        kill_d        = kill_q;
        outstanding_d = outstanding_q + CNT_W'(handshake) - CNT_W'(rvalid_ok);
        if (redirect_valid) begin
            fetch_pc_d = target_pc;
            resp_pc_d  = target_pc;
            kill_d     = outstanding_d;
        end else begin
            if (handshake) begin
                fetch_pc_d = next_pc(fetch_pc_q);
            end
            if (drop_resp) begin
                kill_d = kill_q - CNT_W'(1);
            end
            if (push) begin
                resp_pc_d = next_pc(resp_pc_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            kill_q        <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            kill_q        <= kill_d;
        end
    end

`ifdef IFU_MISALIGN_CHECK_EN
    fetch_state_e state_q, state_d;

    // A misaligned target parks the unit; the kill count loaded on that redirect drains in-flight data.
    always_comb begin
        state_d = state_q;
        if (redirect_valid) begin
            state_d = (redirect_pc[1:0] != 2'b00) ? FETCH_HALTED : FETCH_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    assign halted    = (state_q == FETCH_HALTED);
    assign fetch_err = halted;
`else
    assign halted    = 1'b0;
    assign fetch_err = 1'b0;
`endif

    ifu_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_data  (push_entry),
        .pop        (pop),
        .flush      (redirect_valid),
        .head_valid (instr_valid),
        .head_data  (head_data),
        .count      (fifo_count)
    );

    assign head_entry = fifo_entry_t'(head_data);
    assign instr      = head_entry.word;
    assign instr_pc   = head_entry.pc;

    assert property (@(posedge clk) disable iff (reset)
        !(imem_rvalid && (kill_q == '0) && (fifo_count == CNT_W'(DEPTH))));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: in-order memory model plus an expected PC-stream model.
// Misalignment checks follow IFU_MISALIGN_CHECK_EN.
module tb_instr_fetch_unit;

    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        fetch_err;

    int total = 0;
    int bad   = 0;

    // memory model state
    logic [31:0] mq_addr[$];
    int          mq_due[$];
    int          cyc = 0;
    int          gnt_pct = 100;
    int          lat_max = 0;
    bit          hold_resp = 0;

    // expected fetch address and expected PC of the next consumed instruction
    logic [31:0] m_fetch = RST_PC;
    logic [31:0] m_cons  = RST_PC;

    // observations of the current cycle
    logic        o_req, o_valid, o_err, hs, popped;
    logic [31:0] o_addr, o_instr, o_pc, e_addr, e_pc;

    instr_fetch_unit #(
        .DEPTH    (DEPTH),
        .RESET_PC (RST_PC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready),
        .fetch_err      (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0001;
    endfunction

    // Drives one cycle at the falling edge, samples outputs 1ns later and advances the models.
    task automatic step(input logic rst, input logic redir, input logic [31:0] rpc, input logic rdy);
        @(negedge clk);
        reset          = rst;
        redirect_valid = redir;
        redirect_pc    = rpc;
        instr_ready    = rdy;
        imem_gnt       = ($urandom_range(99) < gnt_pct);
        if (!rst && !hold_resp && mq_addr.size() != 0 && mq_due[0] <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = word_of(mq_addr[0]);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        #1;
        o_req   = imem_req;
        o_addr  = imem_addr;
        o_valid = instr_valid;
        o_instr = instr;
        o_pc    = instr_pc;
        o_err   = fetch_err;
        hs      = imem_req && imem_gnt;
        popped  = instr_valid && instr_ready;
        e_addr  = m_fetch;
        e_pc    = m_cons;
        if (imem_rvalid) begin
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end
        if (rst) begin
            mq_addr.delete();
            mq_due.delete();
            m_fetch = RST_PC;
            m_cons  = RST_PC;
        end else begin
            if (hs) begin
                mq_addr.push_back(imem_addr);
                mq_due.push_back(cyc + 1 + int'($urandom_range(lat_max)));
            end
            if (redir) begin
                m_fetch = rpc & 32'hFFFF_FFFC;
                m_cons  = rpc & 32'hFFFF_FFFC;
            end else begin
                if (hs)     m_fetch = m_fetch + 32'd4;
                if (popped) m_cons  = m_cons + 32'd4;
            end
        end
        cyc++;
    endtask

    task automatic do_reset();
        gnt_pct   = 100;
        lat_max   = 0;
        hold_resp = 0;
        repeat (3) step(1'b1, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        step(1'b1, 1'b0, 32'h0, 1'b1);
        total++; if (o_req !== 1'b0)   begin bad++; $display("[TB] FAIL rst_req got %b want 0", o_req); end
        total++; if (o_addr !== RST_PC) begin bad++; $display("[TB] FAIL rst_addr got %h want %h", o_addr, RST_PC); end
        total++; if (o_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_valid got %b want 0", o_valid); end
        total++; if (o_instr !== 32'h0) begin bad++; $display("[TB] FAIL rst_instr got %h want 0", o_instr); end
        total++; if (o_pc !== 32'h0)   begin bad++; $display("[TB] FAIL rst_pc got %h want 0", o_pc); end
        total++; if (o_err !== 1'b0)   begin bad++; $display("[TB] FAIL rst_err got %b want 0", o_err); end
        step(1'b0, 1'b0, 32'h0, 1'b1);
        total++; if (o_req !== 1'b1 || o_addr !== RST_PC) begin
            bad++; $display("[TB] FAIL first_req got req=%b addr=%h want req=1 addr=%h", o_req, o_addr, RST_PC);
        end
    endtask

    task automatic test_sequential();
        do_reset();
        for (int n = 1; n <= 24; n++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1);
            total++; if (o_req !== 1'b1 || o_addr !== 32'(4 * (n - 1))) begin
                bad++; $display("[TB] FAIL seq_addr cyc%0d got req=%b addr=%h want %h", n, o_req, o_addr, 32'(4 * (n - 1)));
            end
            if (n < 3) begin
                total++; if (o_valid !== 1'b0) begin bad++; $display("[TB] FAIL seq_early_valid cyc%0d got %b want 0", n, o_valid); end
            end else begin
                total++; if (o_valid !== 1'b1 || o_pc !== 32'(4 * (n - 3))) begin
                    bad++; $display("[TB] FAIL seq_pc cyc%0d got v=%b pc=%h want %h", n, o_valid, o_pc, 32'(4 * (n - 3)));
                end
                total++; if (o_instr !== word_of(32'(4 * (n - 3)))) begin
                    bad++; $display("[TB] FAIL seq_word cyc%0d got %h want %h", n, o_instr, word_of(32'(4 * (n - 3))));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int n_hs = 0;
        int n_pop = 0;
        do_reset();
        for (int n = 0; n < 10; n++) begin
            step(1'b0, 1'b0, 32'h0, 1'b0);
            if (hs) n_hs++;
        end
        total++; if (n_hs != DEPTH) begin bad++; $display("[TB] FAIL bp_handshakes got %0d want %0d", n_hs, DEPTH); end
        total++; if (o_req !== 1'b0) begin bad++; $display("[TB] FAIL bp_req_stall got %b want 0", o_req); end
        for (int n = 0; n < 12 && n_pop < DEPTH; n++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1);
            if (popped) begin
                total++; if (o_pc !== 32'(4 * n_pop) || o_instr !== word_of(32'(4 * n_pop))) begin
                    bad++; $display("[TB] FAIL bp_drain got pc=%h w=%h want pc=%h", o_pc, o_instr, 32'(4 * n_pop));
                end
                n_pop++;
            end
        end
        total++; if (n_pop != DEPTH) begin bad++; $display("[TB] FAIL bp_drain_count got %0d want %0d", n_pop, DEPTH); end
    endtask

    task automatic test_redirect_stale();
        int n_hs = 0;
        int n_pop = 0;
        do_reset();
        hold_resp = 1;
        for (int n = 0; n < 3; n++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1);
            if (hs) n_hs++;
        end
        total++; if (n_hs != 3) begin bad++; $display("[TB] FAIL stale_outstanding got %0d want 3", n_hs); end
        step(1'b0, 1'b1, 32'h100, 1'b1);
        total++; if (o_req !== 1'b0) begin bad++; $display("[TB] FAIL stale_req_in_redirect got %b want 0", o_req); end
        hold_resp = 0;
        step(1'b0, 1'b0, 32'h0, 1'b1);
        total++; if (o_req !== 1'b1 || o_addr !== 32'h100 || o_valid !== 1'b0) begin
            bad++; $display("[TB] FAIL stale_restart got req=%b addr=%h v=%b want 1 100 0", o_req, o_addr, o_valid);
        end
        for (int n = 0; n < 20 && n_pop < 2; n++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1);
            if (hs) begin
                total++; if (o_addr !== e_addr) begin bad++; $display("[TB] FAIL stale_fetch got %h want %h", o_addr, e_addr); end
            end
            if (popped) begin
                total++; if (o_pc !== 32'h100 + 32'(4 * n_pop) || o_instr !== word_of(32'h100 + 32'(4 * n_pop))) begin
                    bad++; $display("[TB] FAIL stale_pop got pc=%h w=%h want pc=%h", o_pc, o_instr, 32'h100 + 32'(4 * n_pop));
                end
                n_pop++;
            end
        end
        total++; if (n_pop != 2) begin bad++; $display("[TB] FAIL stale_timeout got %0d pops want 2", n_pop); end
    endtask

    task automatic test_redirect_collision();
        int first_new = -1;
        do_reset();
        repeat (6) step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b1, 32'h400, 1'b1);
        for (int k = 1; k <= 15; k++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1);
            if (k == 1) begin
                total++; if (o_valid !== 1'b0 || o_req !== 1'b1 || o_addr !== 32'h400) begin
                    bad++; $display("[TB] FAIL coll_r1 got v=%b req=%b addr=%h want 0 1 400", o_valid, o_req, o_addr);
                end
            end
            if (popped) begin
                if (first_new < 0) first_new = k;
                total++; if (o_pc !== e_pc || o_instr !== word_of(e_pc)) begin
                    bad++; $display("[TB] FAIL coll_pop got pc=%h w=%h want pc=%h w=%h", o_pc, o_instr, e_pc, word_of(e_pc));
                end
            end
        end
        total++; if (first_new < 3) begin bad++; $display("[TB] FAIL coll_first_valid got R+%0d want >=R+3", first_new); end
        total++; if (m_cons !== 32'h400 + 32'(4 * (15 - first_new + 1))) begin
            bad++; $display("[TB] FAIL coll_stream got next=%h want %h", m_cons, 32'h400 + 32'(4 * (15 - first_new + 1)));
        end
    endtask

    task automatic test_wrap();
        logic [31:0] hs_addrs[$];
        logic [31:0] pop_pcs[$];
        do_reset();
        step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
        for (int n = 0; n < 10; n++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1);
            if (hs) hs_addrs.push_back(o_addr);
            if (popped) begin
                pop_pcs.push_back(o_pc);
                total++; if (o_instr !== word_of(o_pc)) begin bad++; $display("[TB] FAIL wrap_word got %h want %h", o_instr, word_of(o_pc)); end
            end
        end
        total++; if (hs_addrs.size() < 2 || hs_addrs[0] !== 32'hFFFF_FFFC || hs_addrs[1] !== 32'h0) begin
            bad++; $display("[TB] FAIL wrap_fetch got n=%0d want FFFFFFFC then 00000000", hs_addrs.size());
        end
        total++; if (pop_pcs.size() < 2 || pop_pcs[0] !== 32'hFFFF_FFFC || pop_pcs[1] !== 32'h0) begin
            bad++; $display("[TB] FAIL wrap_pc got n=%0d want FFFFFFFC then 00000000", pop_pcs.size());
        end
    endtask

    task automatic test_misalign();
        int n_pop = 0;
        logic [31:0] resume_pc;
        do_reset();
        repeat (4) step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b1, 32'h102, 1'b1);
`ifdef IFU_MISALIGN_CHECK_EN
        for (int n = 0; n < 5; n++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1);
            total++; if (o_err !== 1'b1 || o_req !== 1'b0 || o_valid !== 1'b0) begin
                bad++; $display("[TB] FAIL mis_halt got err=%b req=%b v=%b want 1 0 0", o_err, o_req, o_valid);
            end
        end
        step(1'b0, 1'b1, 32'h200, 1'b1);
        resume_pc = 32'h200;
`else
        resume_pc = 32'h100;
`endif
        step(1'b0, 1'b0, 32'h0, 1'b1);
        total++; if (o_err !== 1'b0 || o_req !== 1'b1 || o_addr !== resume_pc) begin
            bad++; $display("[TB] FAIL mis_resume got err=%b req=%b addr=%h want 0 1 %h", o_err, o_req, o_addr, resume_pc);
        end
        for (int n = 0; n < 10 && n_pop == 0; n++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1);
            if (popped) begin
                n_pop++;
                total++; if (o_pc !== resume_pc || o_instr !== word_of(resume_pc)) begin
                    bad++; $display("[TB] FAIL mis_first_pop got pc=%h want %h", o_pc, resume_pc);
                end
            end
        end
        total++; if (n_pop == 0) begin bad++; $display("[TB] FAIL mis_timeout got 0 pops want 1"); end
    endtask

    task automatic test_random();
        int n_pop = 0;
        do_reset();
        gnt_pct = 60;
        lat_max = 3;
        for (int n = 0; n < 800; n++) begin
            logic redir;
            redir = ($urandom_range(99) < 3);
            step(1'b0, redir, $urandom & 32'hFFFF_FFFC, ($urandom_range(99) < 70));
            if (hs) begin
                total++; if (o_addr !== e_addr) begin bad++; $display("[TB] FAIL rnd_fetch got %h want %h", o_addr, e_addr); end
                total++; if (mq_addr.size() > DEPTH) begin bad++; $display("[TB] FAIL rnd_credit got %0d want <=%0d", mq_addr.size(), DEPTH); end
            end
            if (popped) begin
                n_pop++;
                total++; if (o_pc !== e_pc || o_instr !== word_of(e_pc)) begin
                    bad++; $display("[TB] FAIL rnd_pop got pc=%h w=%h want pc=%h w=%h", o_pc, o_instr, e_pc, word_of(e_pc));
                end
            end
        end
        total++; if (n_pop < 100) begin bad++; $display("[TB] FAIL rnd_progress got %0d pops want >=100", n_pop); end
    endtask

    initial begin
        reset          = 1'b1;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        instr_ready    = 1'b0;
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_stale();
        test_redirect_collision();
        test_wrap();
        test_misalign();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch front end that sits directly upstream of the single-cycle core's decoder. It generates sequential fetch addresses to instruction memory over a request/grant/response handshake and buffers returned words in a small prefetch FIFO. It presents each instruction to the core with its PC over a valid/ready interface. A redirect (jump or branch from the core) flushes the buffer, discards in-flight responses, and restarts fetch at the new PC.

## Interface
- DEPTH, 4: prefetch FIFO entries and maximum outstanding requests; power of 2, ≥2.
- RESET_PC, 32'h0000_0000: first fetch address after reset.

- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request offered this cycle.
- imem_addr  out  32  word-aligned fetch address; valid when imem_req=1.
- imem_gnt  in  1  memory accepts the request this cycle; may depend combinationally on imem_req.
- imem_rvalid  in  1  read data valid; responses return in request order, ≥1 cycle after grant.
- imem_rdata  in  32  instruction word.
- redirect_valid  in  1  core redirects fetch this cycle.
- redirect_pc  in  32  new fetch PC.
- instr_valid  out  1  instr/instr_pc hold a valid instruction.
- instr  out  32  instruction word to the decoder.
- instr_pc  out  32  address of instr.
- instr_ready  in  1  core consumes the instruction when instr_valid & instr_ready.
- fetch_err  out  1  misaligned redirect flag (see Configuration).

## Operation
- fetch_pc register: loads RESET_PC on reset and redirect_pc on redirect. Otherwise increments by 4 on each handshake (imem_req & imem_gnt). Wraps modulo 2^32.
- imem_req = !reset & !redirect_valid & !halted & (fifo_count + outstanding < DEPTH). It is a one-cycle offer: the memory samples it with gnt in the same cycle, and there is no hold requirement.
- imem_addr = fetch_pc.
- outstanding: +1 on handshake, −1 on imem_rvalid, both in the same cycle leave it unchanged. It never exceeds DEPTH.
- kill counter: on redirect, it loads the number of requests still owed. That is outstanding, + 1 if a handshake happens that cycle, − 1 if rvalid arrives that cycle. While kill > 0, each imem_rvalid is dropped (not written) and decrements kill.
- A FIFO entry stores {pc, word}. The write PC comes from a response-PC register that tracks fetch order: it is reloaded on redirect and advanced by 4 on each accepted (non-killed) write.
- Pop on instr_valid & instr_ready. Push and pop may occur in the same cycle.
- Redirect priority: redirect beats push, pop and handshake bookkeeping for FIFO contents. The FIFO is emptied; a pop in the redirect cycle is still treated as consumed by the core.
- An rvalid while kill = 0 and the FIFO is full is impossible by the credit rule; assertion only.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, fetch_err=0; outstanding=0, kill=0, FIFO empty.
- The first request is offered in the first cycle after reset deasserts.
- Latency: a handshake in cycle N with rvalid in N+1 gives instr_valid=1 in N+2. FIFO outputs are registered, with no same-cycle bypass.
- Redirect in cycle R: instr_valid=0 in R+1; a request to redirect_pc is offered in R+1. The first valid new-path instruction appears no earlier than R+3.
- Steady state: one instruction per cycle with instr_ready held high and a single-cycle memory.
- A credit freed by a pop is usable next cycle, not the same cycle.
- Reset mid-operation: all counters are cleared immediately and late responses are ignored until the next handshake. The memory must also be reset.

## Configuration
- IFU_MISALIGN_CHECK_EN defined:
  - A redirect with redirect_pc[1:0] != 0 sets fetch_err=1 and halts the unit: no requests are issued and in-flight responses are killed.
  - fetch_err stays set until an aligned redirect or reset.
- Undefined: redirect_pc[1:0] is forced to 0, fetch_err is tied 0, and there is no halted state.

## Structure
- Package ifu_pkg: XLEN=32, INSTR_BYTES=4, default RESET_PC constant, fifo entry struct {pc, word}.
- Sub-module ifu_fifo: parameterised by DEPTH. Has push/pop/flush ports, registered head output, and count output. The top level holds the PC, credit, and kill logic.

## Test plan
- Reset, then a single-cycle memory with instr_ready=1 → imem_addr sequence 0,4,8,…; instr_pc 0 in cycle 3, then one instruction per cycle.
- instr_ready=0 for 10 cycles, DEPTH=4 → exactly 4 handshakes, then imem_req=0. After ready rises, instructions 0,4,8,12 drain in order.
- 3 outstanding requests, then redirect to 0x100 → the 3 stale responses are dropped, the first instruction seen has instr_pc=0x100, and fetch continues at 0x104.
- Redirect in the same cycle as a handshake and an rvalid → kill is computed correctly and no stale word reaches instr.
- With IFU_MISALIGN_CHECK_EN, redirect to 0x102 → fetch_err=1 and imem_req=0. A following redirect to 0x200 → fetch_err=0 and fetch resumes at 0x200.
- Start at fetch_pc=0xFFFF_FFFC → the next address is 0x0000_0000.
